// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF  = 16;
   localparam int unsigned WORD_LENGTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to 1 (idle line level).
module uart_rx_sync (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= i_async;
         sync_q <= meta_q;
      end
   end

   assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver feeding debug_unit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_error output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF,
   parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_tick,
   input  logic                   i_rx,
   output logic [WORD_LENGTH-1:0] o_data_rx,
   output logic                   o_rx_done,
   output logic                   o_frame_error
`ifdef UART_RX_PARITY_EN
   ,output logic                  o_parity_error
`endif
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(WORD_LENGTH + 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LENGTH - 1);

   logic                   rx_s;
   uart_state_e            state_q;
   logic [TW-1:0]          tick_cnt_q;
   logic [BW-1:0]          bit_cnt_q;
   logic [WORD_LENGTH-1:0] shift_q;
   logic [WORD_LENGTH-1:0] data_q;
   logic                   done_q;
   logic                   ferr_q;
`ifdef UART_RX_PARITY_EN
   logic                   par_q;
   logic                   perr_q;
`endif

   uart_rx_sync u_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (i_rx),
      .o_sync  (rx_s)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               tick_cnt_q <= '0;
               if (!rx_s) state_q <= START;
            end
            // Line still high at mid start bit means a glitch: drop it silently.
            START: if (i_tick) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  state_q    <= rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            DATA: if (i_tick) begin
               if (tick_cnt_q == TICK_END) begin
                  tick_cnt_q <= '0;
                  bit_cnt_q  <= bit_cnt_q + 1'b1;
                  shift_q    <= {rx_s, shift_q[WORD_LENGTH-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (i_tick) begin
               if (tick_cnt_q == TICK_END) begin
                  tick_cnt_q <= '0;
                  par_q      <= rx_s;
                  state_q    <= STOP;
               end else begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
`endif
            // Frame error outranks parity error; the held byte changes only on a clean frame.
            STOP: if (i_tick) begin
               if (tick_cnt_q == TICK_END) begin
                  tick_cnt_q <= '0;
                  state_q    <= IDLE;
                  if (!rx_s) begin
                     ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (par_q != ^shift_q) begin
                     perr_q <= 1'b1;
`endif
                  end else begin
                     data_q <= shift_q;
                     done_q <= 1'b1;
                  end
               end else begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_data_rx     = data_q;
   assign o_rx_done     = done_q;
   assign o_frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected pulses queued, output pulses popped and compared.
module tb_uart_rx;

   localparam int unsigned BIT_CLKS = 64;  // 16 ticks x 4 clocks

   logic       clk;
   logic       i_reset;
   logic       i_tick;
   logic       i_rx;
   logic [7:0] o_data_rx;
   logic       o_rx_done;
   logic       o_frame_error;
   logic       perr_w;

   typedef struct {
      logic [2:0] kind;  // {parity_error, frame_error, rx_done}
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   uart_rx #(.WORD_LENGTH(8), .OVERSAMPLE(16)) dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_tick        (i_tick),
      .i_rx          (i_rx),
      .o_data_rx     (o_data_rx),
      .o_rx_done     (o_rx_done),
      .o_frame_error (o_frame_error)
`ifdef UART_RX_PARITY_EN
      ,.o_parity_error (perr_w)
`endif
   );

`ifndef UART_RX_PARITY_EN
   assign perr_w = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      i_tick = 1'b0;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         i_tick = ((t % 4) == 3);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic expect_ev(input logic [2:0] kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic send_bit(input logic b, input int n);
      i_rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
      send_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip, BIT_CLKS);
`else
      if (par_flip) send_bit(1'b1, 0);
`endif
      if (stop_ok) begin
         send_bit(1'b1, BIT_CLKS);
      end else begin
         // Low only past the stop-bit sample point so the trailing low is rejected as a false start.
         send_bit(1'b0, 44);
         send_bit(1'b1, 84);
      end
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   initial begin
      logic [2:0] obs;
      logic       prev_pulse;
      exp_t       e;
      prev_pulse = 1'b0;
      forever begin
         @(negedge clk);
         obs = {perr_w, o_frame_error, o_rx_done};
         if (!i_reset) begin
            if (prev_pulse) check_eq("pulse_gap", {29'd0, obs}, 32'd0);
            if (obs != 3'b000) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_pulse", {29'd0, obs}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("pulse_kind", {29'd0, obs}, {29'd0, e.kind});
                  check_eq("data_rx", {24'd0, o_data_rx}, {24'd0, e.data});
               end
            end
         end
         prev_pulse = (obs != 3'b000);
      end
   end

   initial begin
      i_rx    = 1'b1;
      i_reset = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("reset_data", {24'd0, o_data_rx}, 32'd0);
      check_eq("reset_done", {31'd0, o_rx_done}, 32'd0);
      check_eq("reset_ferr", {31'd0, o_frame_error}, 32'd0);
      i_reset = 1'b0;
      send_bit(1'b1, 100);

      expect_ev(3'b001, 8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      send_bit(1'b1, 100);

      for (int k = 0; k < 4; k++) expect_ev(3'b001, 8'hFF);
      for (int k = 0; k < 4; k++) send_frame(8'hFF, 1'b1, 1'b0);
      send_bit(1'b1, 100);

      // Glitch of 5 ticks must not start a frame.
      send_bit(1'b0, 20);
      send_bit(1'b1, 200);
      check_eq("glitch_data", {24'd0, o_data_rx}, 32'hFF);
      expect_ev(3'b001, 8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      send_bit(1'b1, 100);

      expect_ev(3'b001, 8'h01);
      send_frame(8'h01, 1'b1, 1'b0);
      expect_ev(3'b010, 8'h01);
      send_frame(8'h3C, 1'b0, 1'b0);
      send_bit(1'b1, 100);
      check_eq("ferr_hold", {24'd0, o_data_rx}, 32'h01);

      // Reset during bit 4 of 0x5A.
      send_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 8'h00, BIT_CLKS);
      send_bit(1'b1, 30);
      i_reset = 1'b1;
      send_bit(1'b1, 2);
      i_reset = 1'b0;
      @(negedge clk);
      check_eq("midreset_data", {24'd0, o_data_rx}, 32'd0);
      send_bit(1'b1, 200);
      check_eq("midreset_idle", {24'd0, o_data_rx}, 32'd0);
      expect_ev(3'b001, 8'h08);
      send_frame(8'h08, 1'b1, 1'b0);
      send_bit(1'b1, 100);
      check_eq("final_data", {24'd0, o_data_rx}, 32'h08);

`ifdef UART_RX_PARITY_EN
      expect_ev(3'b100, 8'h08);
      send_frame(8'h0F, 1'b1, 1'b1);
      send_bit(1'b1, 100);
      expect_ev(3'b001, 8'h0F);
      send_frame(8'h0F, 1'b1, 1'b0);
      send_bit(1'b1, 100);
`endif

      check_eq("pending_events", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that turns the 8N1 line from the host PC into bytes for debug_unit.
- Sits directly upstream of debug_unit and drives its i_data_rx and i_rx_done inputs.
- Oversamples the line using a one-cycle baud tick (16x baud) from the shared baud-rate generator.
- Holds each received byte until the next valid frame arrives.

Parameters:
- WORD_LENGTH, 8, data bits per frame (must match debug_unit OUTPUT_WORD_LENGTH).
- OVERSAMPLE, 16, i_tick pulses per bit period; must be even and at least 4.

Ports:
- i_clock  in  1  system clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  one-cycle pulse, OVERSAMPLE per bit period.
- i_rx  in  1  asynchronous serial line; idles high.
- o_data_rx  out  WORD_LENGTH  last valid byte received, LSB first on the line.
- o_rx_done  out  1  one-cycle pulse when o_data_rx has been updated.
- o_frame_error  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset values: o_data_rx=0, o_rx_done=0, o_frame_error=0, state=IDLE, counters=0, shift register=0, synchroniser FFs=1.
- i_rx always passes through a 2-FF synchroniser; rx_s below is the synchronised value (2 cycles latency).
- Tick counter and bit counter advance only in cycles where i_tick=1.
- IDLE: tick counter=0. On rx_s=0 (checked every clock) go to START.
- START: on the tick where tick counter reaches OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: clear tick counter, clear bit counter, go to DATA.
  - rx_s=1: false start; go to IDLE with no output activity.
- DATA: on the tick where tick counter reaches OVERSAMPLE-1 (mid bit):
  - shift rx_s into the MSB of the shift register (right shift), clear tick counter, increment bit counter.
  - after WORD_LENGTH bits go to STOP (PARITY when the optional feature is compiled in).
- STOP: on the tick where tick counter reaches OVERSAMPLE-1:
  - rx_s=1: o_data_rx <= shift register, o_rx_done=1 for exactly the next clock.
  - rx_s=0: o_frame_error=1 for one clock; o_data_rx unchanged; no o_rx_done.
  - either way go to IDLE. A new start bit is detected from the next clock, so back-to-back frames are received with no gap.
- o_rx_done and o_frame_error are registered, never high together, never high for two consecutive cycles.
- i_rx glitches low for less than OVERSAMPLE/2 ticks are rejected in START.
- i_reset=1 mid-frame: back to IDLE next clock; partial byte discarded; o_data_rx cleared; no pulse emitted.
- No i_tick: FSM holds state indefinitely; no timeout.

Optional Feature:
- Macro UART_RX_PARITY_EN. When defined:
  - adds output o_parity_error (1 bit, reset 0) and state PARITY between DATA and STOP.
  - PARITY samples one even-parity bit at mid-bit.
  - At STOP, if the parity mismatches and the stop bit is 1: o_parity_error pulses 1 clock, no o_rx_done, o_data_rx unchanged.
  - A frame error takes priority over a parity error.
- When undefined: 8N1 only; no PARITY state and no o_parity_error port.

Decomposition:
- Package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP), default OVERSAMPLE, default WORD_LENGTH. Shared with the future uart_tx.
- One sub-module, uart_rx_sync: 2-FF synchroniser with reset value 1, reusable for other asynchronous inputs.

Test Plan:
- Frame 0xA5, i_tick every 4 clocks, OVERSAMPLE=16 -> one o_rx_done pulse, o_data_rx=0xA5, o_frame_error stays 0.
- Four back-to-back 0xFF frames (HALT word), no idle gap -> four o_rx_done pulses, each with o_data_rx=0xFF.
- i_rx low for 5 ticks, then high -> no o_rx_done, no o_frame_error, FSM back in IDLE; following frame 0x07 received correctly.
- Frame 0x3C with stop bit 0 after a valid 0x01 -> o_frame_error pulses once, o_data_rx remains 0x01.
- i_reset=1 during bit 4 of 0x5A, then frame 0x08 -> o_data_rx=0 after reset, then 0x08 with a single o_rx_done pulse.
- With UART_RX_PARITY_EN: 0x0F with parity 1 -> o_parity_error pulse, no o_rx_done; 0x0F with parity 0 -> o_rx_done, o_data_rx=0x0F.
